// File: rtl/joystick_adc_sequencer.sv
// Round-robin DRP read sequencer for four joystick channels (P1X, P1Y, P2X, P2Y).
// Each channel dwells for a settle time, issues one DRP read and captures the
// 4-bit code from drp_do[15:12]. A missing drdy times out and keeps the old code.
// After the fourth channel the codes are decoded and published in one cycle.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   enable             run sweeps while high
//   drp_daddr/den/dwe  DRP request side (dwe tied low)
//   drp_drdy/drp_do    DRP response side
//   ch_codes           last published codes {P2Y, P2X, P1Y, P1X}
//   p1_*/p2_*          decoded per-player step and kick controls
//   sweep_done         one-cycle pulse on publish
//   timeout_err        sticky DRP timeout flag
module joystick_adc_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CENTER         = 8,
  parameter int unsigned GRAVITY        = 5,
  parameter logic [6:0]  ADDR_P1X       = 7'h16,
  parameter logic [6:0]  ADDR_P1Y       = 7'h1E,
  parameter logic [6:0]  ADDR_P2X       = 7'h17,
  parameter logic [6:0]  ADDR_P2Y       = 7'h1F
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  output logic [6:0]         drp_daddr,
  output logic               drp_den,
  output logic               drp_dwe,
  input  logic               drp_drdy,
  input  logic [15:0]        drp_do,
  output logic [15:0]        ch_codes,
  output logic signed [10:0] p1_dx,
  output logic signed [10:0] p1_dy,
  output logic               p1_kick,
  output logic signed [10:0] p2_dx,
  output logic signed [10:0] p2_dy,
  output logic               p2_kick,
  output logic               sweep_done,
  output logic               timeout_err
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned STEP_W  = 11;

  localparam logic [CNT_W-1:0]         SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]         TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]               CENTER_CODE  = 4'(CENTER);
  localparam logic signed [STEP_W-1:0] GRAVITY_DY   = STEP_W'(GRAVITY);
  localparam logic signed [STEP_W-1:0] STEP_POS     = STEP_W'(1);
  localparam logic signed [STEP_W-1:0] STEP_NEG     = '1;
  localparam logic signed [STEP_W-1:0] STEP_ZERO    = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DWELL,
    S_ISSUE,
    S_RESP,
    S_NEXT
  } state_t;

  state_t           state, state_n;
  logic [1:0]       idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0]      shadow, shadow_n;
  logic             err_n;
  logic             publish_c;

  // Only the code nibble of the DRP word is meaningful.
  logic unused_do_low;
  assign unused_do_low = ^drp_do[11:0];

  assign drp_dwe = 1'b0;

  function automatic logic [6:0] chan_addr(input logic [1:0] i);
    case (i)
      2'd0:    chan_addr = ADDR_P1X;
      2'd1:    chan_addr = ADDR_P1Y;
      2'd2:    chan_addr = ADDR_P2X;
      default: chan_addr = ADDR_P2Y;
    endcase
  endfunction

  function automatic logic signed [STEP_W-1:0] decode_dx(input logic [3:0] c);
    if (c > CENTER_CODE)      decode_dx = STEP_POS;
    else if (c < CENTER_CODE) decode_dx = STEP_NEG;
    else                      decode_dx = STEP_ZERO;
  endfunction

  // Pulling a Y stick down means kick, not a downward step.
  function automatic logic signed [STEP_W-1:0] decode_dy(input logic [3:0] c);
    if (c > CENTER_CODE)      decode_dy = STEP_POS;
    else if (c < CENTER_CODE) decode_dy = STEP_ZERO;
    else                      decode_dy = GRAVITY_DY;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state and datapath next values.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    shadow_n  = shadow;
    err_n     = timeout_err;
    publish_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_n = S_DWELL;
          cnt_n   = '0;
        end
      end
      S_DWELL: begin
        if (cnt == SETTLE_LAST) state_n = S_ISSUE;
        else                    cnt_n   = cnt + CNT_W'(1);
      end
      S_ISSUE: begin
        state_n = S_RESP;
        cnt_n   = '0;
      end
      S_RESP: begin
        // A response on the last timeout cycle still wins over the timeout.
        if (drp_drdy) begin
          shadow_n[{idx, 2'b00} +: 4] = drp_do[15:12];
          state_n = S_NEXT;
        end else if (cnt == TIMEOUT_LAST) begin
          err_n   = 1'b1;
          state_n = S_NEXT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_NEXT: begin
        cnt_n = '0;
        if (idx == 2'd3) begin
          publish_c = 1'b1;
          idx_n     = 2'd0;
        end else begin
          idx_n = idx + 2'd1;
        end
        // Dropping enable abandons the partial sweep and restarts at P1X.
        if (enable) begin
          state_n = S_DWELL;
        end else begin
          state_n = S_IDLE;
          idx_n   = 2'd0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Sequencer registers, DRP request outputs and published controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= 2'd0;
      cnt         <= '0;
      shadow      <= 16'h8888;
      timeout_err <= 1'b0;
      drp_den     <= 1'b0;
      drp_daddr   <= ADDR_P1X;
      ch_codes    <= 16'h8888;
      p1_dx       <= STEP_ZERO;
      p1_dy       <= GRAVITY_DY;
      p1_kick     <= 1'b0;
      p2_dx       <= STEP_ZERO;
      p2_dy       <= GRAVITY_DY;
      p2_kick     <= 1'b0;
      sweep_done  <= 1'b0;
    end else begin
      idx         <= idx_n;
      cnt         <= cnt_n;
      shadow      <= shadow_n;
      timeout_err <= err_n;
      drp_den     <= (state_n == S_ISSUE);
      drp_daddr   <= chan_addr(idx_n);
      sweep_done  <= publish_c;
      if (publish_c) begin
        ch_codes <= shadow;
        p1_dx    <= decode_dx(shadow[3:0]);
        p1_dy    <= decode_dy(shadow[7:4]);
        p1_kick  <= (shadow[7:4] < CENTER_CODE);
        p2_dx    <= decode_dx(shadow[11:8]);
        p2_dy    <= decode_dy(shadow[15:12]);
        p2_kick  <= (shadow[15:12] < CENTER_CODE);
      end
    end
  end

endmodule

// File: tb/tb_joystick_adc_sequencer.sv
// Scoreboard bench for joystick_adc_sequencer: stimulus pushes expected DRP
// addresses and published controls; a monitor pops and compares on den/sweep_done.
module tb_joystick_adc_sequencer;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned TMO    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        drp_dwe;
  logic        drp_drdy;
  logic [15:0] drp_do;
  logic [15:0] ch_codes;
  logic [10:0] p1_dx, p1_dy, p2_dx, p2_dy;
  logic        p1_kick, p2_kick;
  logic        sweep_done;
  logic        timeout_err;

  always #5 clk = ~clk;

  joystick_adc_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .drp_daddr  (drp_daddr),
    .drp_den    (drp_den),
    .drp_dwe    (drp_dwe),
    .drp_drdy   (drp_drdy),
    .drp_do     (drp_do),
    .ch_codes   (ch_codes),
    .p1_dx      (p1_dx),
    .p1_dy      (p1_dy),
    .p1_kick    (p1_kick),
    .p2_dx      (p2_dx),
    .p2_dy      (p2_dy),
    .p2_kick    (p2_kick),
    .sweep_done (sweep_done),
    .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [15:0] codes;
    logic [10:0] p1dx;
    logic [10:0] p1dy;
    logic        p1k;
    logic [10:0] p2dx;
    logic [10:0] p2dy;
    logic        p2k;
  } pub_t;

  logic [6:0] exp_addr[$];
  pub_t       exp_pub[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int sweeps = 0;
  int extra_den = 0;
  int den_cyc_17 = 0;
  int den_cyc_1f = 0;

  logic [3:0] code_p1x, code_p1y, code_p2x, code_p2y;
  logic       withhold_p2x;
  logic       ignore_den;
  int         spur_req = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_sweep(input pub_t p);
    exp_addr.push_back(7'h16);
    exp_addr.push_back(7'h1E);
    exp_addr.push_back(7'h17);
    exp_addr.push_back(7'h1F);
    exp_pub.push_back(p);
  endtask

  task automatic set_codes(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
    code_p1x = a; code_p1y = b; code_p2x = c; code_p2y = d;
  endtask

  task automatic wait_sweep(input string name);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (sweep_done) seen = 1;
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_addr(input logic [6:0] a, input string name);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (drp_daddr == a && !drp_den) seen = 1;
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_den(input string name);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (drp_den) seen = 1;
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  function automatic logic [3:0] code_of(input logic [6:0] a);
    case (a)
      7'h16:   code_of = code_p1x;
      7'h1E:   code_of = code_p1y;
      7'h17:   code_of = code_p2x;
      default: code_of = code_p2y;
    endcase
  endfunction

  // DRP model: drdy two cycles after den, optional withheld P2X, spurious drdy on request.
  initial begin
    int pend = 0;
    int spur_done = 0;
    logic [6:0] pend_addr = 7'h0;
    drp_drdy = 1'b0;
    drp_do   = 16'h0000;
    forever begin
      @(negedge clk);
      drp_drdy = 1'b0;
      if (rst) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            drp_drdy = 1'b1;
            drp_do   = {code_of(pend_addr), 12'h5A5};
          end
        end
        if (spur_req != spur_done) begin
          spur_done = spur_req;
          drp_drdy  = 1'b1;
          drp_do    = 16'hE000;
        end
        if (drp_den && !(withhold_p2x && drp_daddr == 7'h17)) begin
          pend      = 2;
          pend_addr = drp_daddr;
        end
      end
    end
  end

  // Monitor: compares every den address and every published sweep.
  initial begin
    pub_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst && drp_den) begin
        if (drp_daddr == 7'h17) den_cyc_17 = cyc;
        if (drp_daddr == 7'h1F) den_cyc_1f = cyc;
        if (ignore_den) extra_den++;
        else if (exp_addr.size() == 0) chk("unexpected_den", {25'd0, drp_daddr}, 32'hFFFF_FFFF);
        else chk("den_addr", {25'd0, drp_daddr}, {25'd0, exp_addr.pop_front()});
      end
      if (!rst && sweep_done) begin
        sweeps++;
        if (exp_pub.size() == 0) begin
          chk("unexpected_sweep_done", 32'd1, 32'd0);
        end else begin
          e = exp_pub.pop_front();
          chk("ch_codes", {16'd0, ch_codes}, {16'd0, e.codes});
          chk("p1_dx", {21'd0, p1_dx}, {21'd0, e.p1dx});
          chk("p1_dy", {21'd0, p1_dy}, {21'd0, e.p1dy});
          chk("p1_kick", {31'd0, p1_kick}, {31'd0, e.p1k});
          chk("p2_dx", {21'd0, p2_dx}, {21'd0, e.p2dx});
          chk("p2_dy", {21'd0, p2_dy}, {21'd0, e.p2dy});
          chk("p2_kick", {31'd0, p2_kick}, {31'd0, e.p2k});
        end
      end
    end
  end

  initial begin
    int sweeps_before;
    rst          = 1'b1;
    enable       = 1'b0;
    withhold_p2x = 1'b0;
    ignore_den   = 1'b0;
    set_codes(4'hF, 4'hF, 4'hF, 4'hF);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_den", {31'd0, drp_den}, 32'd0);
    chk("rst_daddr", {25'd0, drp_daddr}, 32'h16);
    chk("rst_dwe", {31'd0, drp_dwe}, 32'd0);
    chk("rst_ch_codes", {16'd0, ch_codes}, 32'h8888);
    chk("rst_p1_dx", {21'd0, p1_dx}, 32'd0);
    chk("rst_p1_dy", {21'd0, p1_dy}, 32'd5);
    chk("rst_p2_dy", {21'd0, p2_dy}, 32'd5);
    chk("rst_kicks", {30'd0, p1_kick, p2_kick}, 32'd0);
    chk("rst_sweep_done", {31'd0, sweep_done}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);

    // All codes F: full positive deflection
    rst = 1'b0;
    @(negedge clk);
    push_sweep('{16'hFFFF, 11'd1, 11'd1, 1'b0, 11'd1, 11'd1, 1'b0});
    enable = 1'b1;
    wait_sweep("sweep_allF");
    chk("no_timeout_1", {31'd0, timeout_err}, 32'd0);

    // Mixed codes below and at center
    set_codes(4'h3, 4'h2, 4'h8, 4'h8);
    push_sweep('{16'h8823, 11'h7FF, 11'd0, 1'b1, 11'd0, 11'd5, 1'b0});
    wait_sweep("sweep_mixed");

    // P2X withheld -> timeout, old code kept; spurious drdy in P2X dwell ignored
    set_codes(4'hA, 4'h8, 4'h1, 4'hC);
    withhold_p2x = 1'b1;
    push_sweep('{16'hC88A, 11'd1, 11'd5, 1'b0, 11'd0, 11'd1, 1'b0});
    wait_addr(7'h17, "p2x_dwell");
    spur_req++;
    wait_sweep("sweep_timeout");
    chk("timeout_gap", den_cyc_1f - den_cyc_17, 32'd14);
    chk("timeout_err_set", {31'd0, timeout_err}, 32'd1);
    withhold_p2x = 1'b0;

    // Normal sweep; timeout_err stays sticky
    set_codes(4'h5, 4'hF, 4'h1, 4'h0);
    push_sweep('{16'h01F5, 11'h7FF, 11'd1, 1'b0, 11'h7FF, 11'd0, 1'b1});
    wait_sweep("sweep_after_timeout");
    chk("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);

    // Drop enable during P1Y dwell
    exp_addr.push_back(7'h16);
    wait_addr(7'h1E, "p1y_dwell");
    ignore_den    = 1'b1;
    enable        = 1'b0;
    sweeps_before = sweeps;
    repeat (150) @(negedge clk);
    chk("dens_after_disable_le1", {31'd0, (extra_den <= 1)}, 32'd1);
    chk("no_partial_publish", sweeps, sweeps_before);
    chk("codes_held_idle", {16'd0, ch_codes}, 32'h01F5);

    // Re-enable starts at P1X
    ignore_den = 1'b0;
    set_codes(4'h8, 4'hF, 4'h0, 4'h8);
    push_sweep('{16'h80F8, 11'd0, 11'd1, 1'b0, 11'h7FF, 11'd5, 1'b0});
    enable = 1'b1;
    wait_sweep("sweep_reenable");

    // Reset while in RESP with drdy present in the same cycle
    exp_addr.push_back(7'h16);
    wait_den("p1x_den_before_rst");
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_ch_codes", {16'd0, ch_codes}, 32'h8888);
    chk("rst_mid_p1_dy", {21'd0, p1_dy}, 32'd5);
    chk("rst_mid_p2_dy", {21'd0, p2_dy}, 32'd5);
    chk("rst_mid_p2_dx", {21'd0, p2_dx}, 32'd0);
    chk("rst_mid_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_mid_den", {31'd0, drp_den}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    set_codes(4'hF, 4'h0, 4'h7, 4'h9);
    push_sweep('{16'h970F, 11'd1, 11'd0, 1'b1, 11'h7FF, 11'd1, 1'b0});
    rst = 1'b0;
    wait_sweep("sweep_after_rst");
    chk("timeout_err_after_rst", {31'd0, timeout_err}, 32'd0);

    // Wind down
    ignore_den = 1'b1;
    enable     = 1'b0;
    repeat (40) @(negedge clk);
    chk("addr_queue_drained", exp_addr.size(), 32'd0);
    chk("pub_queue_drained", exp_pub.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
